// File: rtl/cell_sched_pkg.sv
// Shared types and defaults for the cell scheduler slice.
package cell_sched_pkg;

   localparam int PIXEL_W_DEF = 24;
   localparam int OP_W_DEF    = 4;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_WAIT    = 2'd2,
      S_RESPOND = 2'd3
   } state_t;

   typedef logic [PIXEL_W_DEF-1:0] pixel_t;
   typedef logic [OP_W_DEF-1:0]    opcode_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request after i_last, wrapping.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_last,
   output logic [N-1:0]  o_grant,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   int w_k;

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      w_k     = 0;
      // i runs 1..N so the previous winner is considered last
      for (int i = 1; i <= N; i++) begin
         w_k = (int'(i_last) + i) % N;
         if (!o_any && i_req[IW'(w_k)]) begin
            o_any              = 1'b1;
            o_idx              = IW'(w_k);
            o_grant[IW'(w_k)]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cell_scheduler.sv
// Shares one cell processor among NUM_REQ pixel sources: round-robin accept,
// one-cycle start pulse, fixed-latency capture, valid/ready response.
module cell_scheduler
   import cell_sched_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int PIXEL_W      = PIXEL_W_DEF,
   parameter int OP_W         = OP_W_DEF,
   parameter int CELL_LATENCY = 1
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic [NUM_REQ-1:0]         i_req_valid,
   output logic [NUM_REQ-1:0]         o_req_ready,
   input  logic [NUM_REQ*PIXEL_W-1:0] i_req_pixel_a,
   input  logic [NUM_REQ*PIXEL_W-1:0] i_req_pixel_b,
   input  logic [NUM_REQ*OP_W-1:0]    i_req_opcode,
   output logic [PIXEL_W-1:0]         o_cell_pixel_a,
   output logic [PIXEL_W-1:0]         o_cell_pixel_b,
   output logic [OP_W-1:0]            o_cell_opcode,
   output logic                       o_cell_start,
   input  logic [PIXEL_W-1:0]         i_cell_result,
   output logic                       o_rsp_valid,
   input  logic                       i_rsp_ready,
   output logic [PIXEL_W-1:0]         o_rsp_pixel,
   output logic [$clog2(NUM_REQ)-1:0] o_rsp_id,
   output logic                       o_busy
);

   // state     | meaning
   // S_IDLE    | waiting for any request; grant is accepted in this cycle
   // S_ISSUE   | cell_start pulse, latency counter loaded
   // S_WAIT    | counting down; result captured when counter is 1
   // S_RESPOND | response held until rsp_ready

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(CELL_LATENCY + 1);

   state_t               r_state;
   logic [IW-1:0]        r_last;
   logic [IW-1:0]        r_gid;
   logic [CW-1:0]        r_cnt;
   logic [PIXEL_W-1:0]   r_pixel_a;
   logic [PIXEL_W-1:0]   r_pixel_b;
   logic [OP_W-1:0]      r_opcode;
   logic                 r_cell_start;
   logic                 r_rsp_valid;
   logic [PIXEL_W-1:0]   r_rsp_pixel;
   logic [IW-1:0]        r_rsp_id;
   logic                 r_busy;

   logic [NUM_REQ-1:0]   w_grant;
   logic [IW-1:0]        w_idx;
   logic                 w_any;
   logic [PIXEL_W-1:0]   w_pa [NUM_REQ];
   logic [PIXEL_W-1:0]   w_pb [NUM_REQ];
   logic [OP_W-1:0]      w_op [NUM_REQ];

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         w_pa[i] = i_req_pixel_a[i*PIXEL_W +: PIXEL_W];
         w_pb[i] = i_req_pixel_b[i*PIXEL_W +: PIXEL_W];
         w_op[i] = i_req_opcode[i*OP_W +: OP_W];
      end
   end

   rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
      .i_req   (i_req_valid),
      .i_last  (r_last),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   // Gated by reset so no accept is advertised while the block is being cleared
   assign o_req_ready = (r_state == S_IDLE && !i_reset) ? w_grant : '0;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_last       <= IW'(NUM_REQ - 1);
         r_gid        <= '0;
         r_cnt        <= '0;
         r_pixel_a    <= '0;
         r_pixel_b    <= '0;
         r_opcode     <= '0;
         r_cell_start <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_rsp_pixel  <= '0;
         r_rsp_id     <= '0;
         r_busy       <= 1'b0;
      end else begin
         r_cell_start <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_pixel_a    <= w_pa[w_idx];
                  r_pixel_b    <= w_pb[w_idx];
                  r_opcode     <= w_op[w_idx];
                  r_gid        <= w_idx;
                  r_last       <= w_idx;
                  r_cell_start <= 1'b1;
                  r_busy       <= 1'b1;
                  r_state      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_cnt   <= CW'(CELL_LATENCY);
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == CW'(1)) begin
                  r_rsp_pixel <= i_cell_result;
                  r_rsp_id    <= r_gid;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_RESPOND;
               end
            end
            S_RESPOND: begin
               if (i_rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_cell_pixel_a = r_pixel_a;
   assign o_cell_pixel_b = r_pixel_b;
   assign o_cell_opcode  = r_opcode;
   assign o_cell_start   = r_cell_start;
   assign o_rsp_valid    = r_rsp_valid;
   assign o_rsp_pixel    = r_rsp_pixel;
   assign o_rsp_id       = r_rsp_id;
   assign o_busy         = r_busy;

endmodule

// File: tb/tb_cell_scheduler.sv
// Directed bench: dut (latency 2, per-channel adder cell) and dut1 (latency 1, counting cell).
module tb_cell_scheduler;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass = 0;

   logic [3:0]  req_valid = '0;
   logic [3:0]  req_ready;
   logic [95:0] req_pa = '0, req_pb = '0;
   logic [15:0] req_op = '0;
   logic [23:0] cell_pa, cell_pb, cell_result, rsp_pixel;
   logic [3:0]  cell_op;
   logic        cell_start, rsp_valid, busy;
   logic        rsp_ready = 1'b0;
   logic [1:0]  rsp_id;

   assign cell_result = {cell_pa[23:16] + cell_pb[23:16],
                         cell_pa[15:8]  + cell_pb[15:8],
                         cell_pa[7:0]   + cell_pb[7:0]};

   cell_scheduler #(.NUM_REQ(4), .PIXEL_W(24), .OP_W(4), .CELL_LATENCY(2)) dut (
      .i_clk(clk), .i_reset(reset),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_pixel_a(req_pa), .i_req_pixel_b(req_pb), .i_req_opcode(req_op),
      .o_cell_pixel_a(cell_pa), .o_cell_pixel_b(cell_pb), .o_cell_opcode(cell_op),
      .o_cell_start(cell_start), .i_cell_result(cell_result),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
      .o_rsp_pixel(rsp_pixel), .o_rsp_id(rsp_id), .o_busy(busy)
   );

   logic [3:0]  req1_valid = '0;
   logic [3:0]  req1_ready;
   logic [95:0] req1_pa = '0, req1_pb = '0;
   logic [15:0] req1_op = '0;
   logic [23:0] cell1_pa, cell1_pb, cell1_result, rsp1_pixel;
   logic [3:0]  cell1_op;
   logic        cell1_start, rsp1_valid, busy1;
   logic        rsp1_ready = 1'b0;
   logic [1:0]  rsp1_id;

   assign cell1_result = cyc[23:0];

   cell_scheduler #(.NUM_REQ(4), .PIXEL_W(24), .OP_W(4), .CELL_LATENCY(1)) dut1 (
      .i_clk(clk), .i_reset(reset),
      .i_req_valid(req1_valid), .o_req_ready(req1_ready),
      .i_req_pixel_a(req1_pa), .i_req_pixel_b(req1_pb), .i_req_opcode(req1_op),
      .o_cell_pixel_a(cell1_pa), .o_cell_pixel_b(cell1_pb), .o_cell_opcode(cell1_op),
      .o_cell_start(cell1_start), .i_cell_result(cell1_result),
      .o_rsp_valid(rsp1_valid), .i_rsp_ready(rsp1_ready),
      .o_rsp_pixel(rsp1_pixel), .o_rsp_id(rsp1_id), .o_busy(busy1)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [23:0] a, input logic [23:0] b,
                          input logic [3:0] op);
      req_pa[i*24 +: 24] = a;
      req_pb[i*24 +: 24] = b;
      req_op[i*4 +: 4]   = op;
   endtask

   task automatic wait_grant(input string name);
      int k = 0;
      #1;
      while (req_ready === 4'b0 && k < 20) begin
         step(); #1; k++;
      end
      n_checks++;
      if (k >= 20) $display("FAIL %s: no grant within %0d cycles, required one", name, k);
      else n_pass++;
   endtask

   task automatic wait_rsp(input string name);
      int k = 0;
      while (rsp_valid !== 1'b1 && k < 20) begin
         step(); k++;
      end
      n_checks++;
      if (k >= 20) $display("FAIL %s: no rsp_valid within %0d cycles, required one", name, k);
      else n_pass++;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(); step(); #1;
      n_checks++;
      if ({busy, cell_start, rsp_valid, req_ready} !== 7'b0)
         $display("FAIL reset_ctrl: got %b expected 0", {busy, cell_start, rsp_valid, req_ready});
      else n_pass++;
      n_checks++;
      if ({cell_pa, cell_pb, cell_op, rsp_pixel, rsp_id} !== 78'b0)
         $display("FAIL reset_data: got %h expected 0", {cell_pa, cell_pb, cell_op, rsp_pixel, rsp_id});
      else n_pass++;
      n_checks++;
      if ({busy1, rsp1_valid, cell1_start} !== 3'b0)
         $display("FAIL reset_dut1: got %b expected 000", {busy1, rsp1_valid, cell1_start});
      else n_pass++;
      reset = 1'b0;
      #1;
      n_checks++;
      if (req_ready !== 4'b0) $display("FAIL reset_idle_ready: got %b expected 0000", req_ready);
      else n_pass++;
   endtask

   task automatic test_single();
      int t;
      set_req(2, 24'h102030, 24'h010203, 4'h1);
      req_valid = 4'b0100;
      #1;
      n_checks++;
      if (req_ready !== 4'b0100) $display("FAIL single_ready: got %b expected 0100", req_ready);
      else n_pass++;
      t = cyc;
      step();
      req_valid = 4'b0;
      #1;
      n_checks++;
      if ({cell_start, busy, req_ready} !== 6'b110000)
         $display("FAIL single_issue: got %b expected 110000", {cell_start, busy, req_ready});
      else n_pass++;
      n_checks++;
      if ({cell_pa, cell_pb, cell_op} !== {24'h102030, 24'h010203, 4'h1})
         $display("FAIL single_operands: got %h expected %h", {cell_pa, cell_pb, cell_op},
                  {24'h102030, 24'h010203, 4'h1});
      else n_pass++;
      step();
      n_checks++;
      if (cell_start !== 1'b0) $display("FAIL single_start_pulse: got %b expected 0", cell_start);
      else n_pass++;
      wait_rsp("single_wait_rsp");
      n_checks++;
      if (cyc - t !== 4) $display("FAIL single_latency: got %0d expected 4", cyc - t);
      else n_pass++;
      n_checks++;
      if ({rsp_pixel, rsp_id} !== {24'h112233, 2'd2})
         $display("FAIL single_rsp: got %h/%0d expected 112233/2", rsp_pixel, rsp_id);
      else n_pass++;
      n_checks++;
      if (cell_pa !== 24'h102030) $display("FAIL single_hold_a: got %h expected 102030", cell_pa);
      else n_pass++;
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      n_checks++;
      if ({rsp_valid, busy} !== 2'b00) $display("FAIL single_done: got %b expected 00", {rsp_valid, busy});
      else n_pass++;
   endtask

   task automatic test_latency1();
      int t;
      int s;
      int k;
      req1_pa[3*24 +: 24] = 24'h555555;
      req1_valid = 4'b1000;
      rsp1_ready = 1'b0;
      #1;
      n_checks++;
      if (req1_ready !== 4'b1000) $display("FAIL lat1_ready: got %b expected 1000", req1_ready);
      else n_pass++;
      t = cyc;
      step();
      req1_valid = 4'b0;
      n_checks++;
      if (cell1_start !== 1'b1) $display("FAIL lat1_start: got %b expected 1", cell1_start);
      else n_pass++;
      s = cyc;
      k = 0;
      while (rsp1_valid !== 1'b1 && k < 20) begin step(); k++; end
      n_checks++;
      if (cyc - t !== 3) $display("FAIL lat1_latency: got %0d expected 3", cyc - t);
      else n_pass++;
      n_checks++;
      if ({rsp1_pixel, rsp1_id} !== {24'(s + 1), 2'd3})
         $display("FAIL lat1_capture: got %h/%0d expected %h/3", rsp1_pixel, rsp1_id, 24'(s + 1));
      else n_pass++;
      rsp1_ready = 1'b1;
      step();
      rsp1_ready = 1'b0;
   endtask

   task automatic test_round_robin();
      int order [6] = '{0, 1, 2, 3, 0, 1};
      logic [23:0] sums [4] = '{24'h111111, 24'h121212, 24'h131313, 24'h141414};
      int prev = 0;
      int k;
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) set_req(i, 24'(24'h010101 * (i + 1)), 24'h101010, 4'(i));
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      for (int g = 0; g < 6; g++) begin
         k = 0;
         #1;
         while (req_ready === 4'b0 && k < 20) begin
            if (g > 0 && rsp_valid === 1'b1) begin
               n_checks++;
               if ({rsp_id, rsp_pixel} !== {2'(order[g-1]), sums[order[g-1]]})
                  $display("FAIL rr_rsp: got %0d/%h expected %0d/%h", rsp_id, rsp_pixel,
                           order[g-1], sums[order[g-1]]);
               else n_pass++;
            end
            step(); #1; k++;
         end
         n_checks++;
         if (req_ready !== 4'(1 << order[g]))
            $display("FAIL rr_grant: grant %0d got %b expected %b", g, req_ready, 4'(1 << order[g]));
         else n_pass++;
         if (g > 0) begin
            n_checks++;
            if (cyc - prev !== 5) $display("FAIL rr_spacing: got %0d expected 5", cyc - prev);
            else n_pass++;
         end
         prev = cyc;
         step();
      end
      req_valid = 4'b0;
      wait_rsp("rr_last_wait");
      n_checks++;
      if ({rsp_id, rsp_pixel} !== {2'd1, 24'h121212})
         $display("FAIL rr_last_rsp: got %0d/%h expected 1/121212", rsp_id, rsp_pixel);
      else n_pass++;
      step();
   endtask

   task automatic test_wrap();
      req_valid = 4'b1000;
      wait_grant("wrap_pre");
      step();
      req_valid = 4'b0;
      wait_rsp("wrap_pre_rsp");
      step();
      req_valid = 4'b1010;
      #1;
      n_checks++;
      if (req_ready !== 4'b0010) $display("FAIL wrap_first: got %b expected 0010", req_ready);
      else n_pass++;
      step();
      wait_grant("wrap_second_wait");
      n_checks++;
      if (req_ready !== 4'b1000) $display("FAIL wrap_second: got %b expected 1000", req_ready);
      else n_pass++;
      step();
      req_valid = 4'b0;
      wait_rsp("wrap_drain");
      step();
   endtask

   task automatic test_backpressure();
      rsp_ready = 1'b0;
      set_req(0, 24'hff8001, 24'h0102ff, 4'h7);
      set_req(1, 24'h000001, 24'h000002, 4'h2);
      req_valid = 4'b0001;
      wait_grant("bp_accept");
      step();
      req_valid = 4'b0010;
      wait_rsp("bp_wait_rsp");
      for (int i = 0; i < 10; i++) begin
         #1;
         n_checks++;
         if ({rsp_valid, rsp_pixel, rsp_id, req_ready, busy} !== {1'b1, 24'h008200, 2'd0, 4'b0, 1'b1})
            $display("FAIL bp_hold: cycle %0d got %b/%h/%0d/%b/%b expected 1/008200/0/0000/1",
                     i, rsp_valid, rsp_pixel, rsp_id, req_ready, busy);
         else n_pass++;
         step();
      end
      rsp_ready = 1'b1;
      step();
      n_checks++;
      if (rsp_valid !== 1'b0) $display("FAIL bp_release: got %b expected 0", rsp_valid);
      else n_pass++;
      #1;
      n_checks++;
      if (req_ready !== 4'b0010) $display("FAIL bp_next_grant: got %b expected 0010", req_ready);
      else n_pass++;
      step();
      req_valid = 4'b0;
      wait_rsp("bp_drain");
      step();
   endtask

   task automatic test_reset_in_wait();
      logic seen = 1'b0;
      rsp_ready = 1'b1;
      set_req(2, 24'h0a0b0c, 24'h010101, 4'h3);
      req_valid = 4'b0100;
      wait_grant("rw_accept");
      n_checks++;
      if (req_ready !== 4'b0100) $display("FAIL rw_grant: got %b expected 0100", req_ready);
      else n_pass++;
      step();
      req_valid = 4'b0;
      step();
      reset = 1'b1;
      step();
      #1;
      n_checks++;
      if ({busy, cell_start, rsp_valid, req_ready, cell_pa, cell_pb, cell_op, rsp_pixel, rsp_id} !== 85'b0)
         $display("FAIL rw_cleared: got %h expected 0",
                  {busy, cell_start, rsp_valid, req_ready, cell_pa, cell_pb, cell_op, rsp_pixel, rsp_id});
      else n_pass++;
      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (rsp_valid === 1'b1) seen = 1'b1;
         step();
      end
      n_checks++;
      if (seen !== 1'b0) $display("FAIL rw_no_rsp: got rsp_valid seen=%b expected 0", seen);
      else n_pass++;
      req_valid = 4'hF;
      #1;
      n_checks++;
      if (req_ready !== 4'b0001) $display("FAIL rw_grant0: got %b expected 0001", req_ready);
      else n_pass++;
      step();
      req_valid = 4'b0;
      wait_rsp("rw_drain");
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single();
      test_latency1();
      test_round_robin();
      test_wrap();
      test_backpressure();
      test_reset_in_wait();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cell_scheduler.md
Name: cell_scheduler

Overview:
- Round-robin scheduler that shares one CellProcessor among NUM_REQ pixel sources, such as switch-driven test inputs or future frame readers.
- Accepts one operation (two RGB pixels plus opcode) per requester handshake and drives it into the cell with a one-cycle start pulse.
- Samples the result after a fixed latency and returns it on a valid/ready response port, tagged with the requester id.
- Sits between the pixel sources and the cellProcessor interface ports.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- PIXEL_W, 24, RGB pixel width (3 x 8-bit channels).
- OP_W, 4, opcode width.
- CELL_LATENCY, 1, cycles from the cell_start cycle to valid cell_result (>=1).

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_pixel_a  in  NUM_REQ*PIXEL_W  packed cellA pixels; requester i occupies [i*PIXEL_W +: PIXEL_W].
- req_pixel_b  in  NUM_REQ*PIXEL_W  packed cellB pixels, same packing.
- req_opcode  in  NUM_REQ*OP_W  packed opcodes.
- cell_pixel_a  out  PIXEL_W  operand A to the cell.
- cell_pixel_b  out  PIXEL_W  operand B to the cell.
- cell_opcode  out  OP_W  opcode to the cell.
- cell_start  out  1  one-cycle issue pulse.
- cell_result  in  PIXEL_W  processed pixel from the cell.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_pixel  out  PIXEL_W  captured result.
- rsp_id  out  $clog2(NUM_REQ)  index of the originating requester.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; every output 0.
  - last_grant=NUM_REQ-1, so the first grant goes to requester 0.
  - Reset during ISSUE, WAIT or RESPOND discards the in-flight operation; no response is ever produced for it.
- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- IDLE:
  - If any req_valid is high, grant g = the first valid index searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - req_ready[g]=1 combinationally in this cycle only.
  - Latch pixel_a, pixel_b, opcode and g; set last_grant=g; go to ISSUE.
  - req_ready is 0 in every other state.
- ISSUE:
  - cell_start=1 for exactly this cycle.
  - Latched operands appear on cell_pixel_a, cell_pixel_b and cell_opcode.
  - Load the latency counter with CELL_LATENCY; go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - On the cycle the counter is 1, capture cell_result into rsp_pixel, set rsp_id=g, go to RESPOND.
  - cell_result is therefore sampled exactly CELL_LATENCY cycles after the cell_start cycle.
- RESPOND:
  - rsp_valid=1; rsp_pixel and rsp_id are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, go to IDLE with rsp_valid=0 on the next cycle.
- Timing, with the handshake at cycle T:
  - cell_start at T+1.
  - rsp_valid first high at T+2+CELL_LATENCY.
  - Minimum spacing between accepts is CELL_LATENCY+3 cycles.
- Operand outputs remain stable from ISSUE through RESPOND and change only on the next accept.
- Requester inputs are ignored outside the IDLE accept cycle. A requester dropping valid before it is granted loses nothing.
- rsp_ready asserted outside RESPOND has no effect.
- Simultaneous requests are resolved by round-robin only; there is no fixed priority. A continuously valid requester is served at least once every NUM_REQ operations.

Decomposition:
- Package cell_sched_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, RESPOND);
  - pixel_t typedef (PIXEL_W bits) and opcode_t typedef (OP_W bits);
  - default constants for PIXEL_W and OP_W.
- Sub-module rr_arbiter (parameter N) is natural:
  - inputs req[N] and last_grant; outputs a one-hot grant and a grant index;
  - purely combinational;
  - instantiated once.

Test Plan:
- Single request: NUM_REQ=4, CELL_LATENCY=2, cell model result = A+B per channel. Req 2 with A=24'h102030, B=24'h010203, op=4'h1, accepted at T → cell_start at T+1; rsp_valid at T+4 with rsp_pixel=24'h112233, rsp_id=2.
- All four requesters held valid, rsp_ready=1 → grant order 0,1,2,3,0,1; accepts spaced exactly 5 cycles apart.
- Wrap-around: last_grant=3, only req 1 and req 3 valid → grant to 1; with the same inputs the next grant goes to 3.
- Backpressure: rsp_ready=0 for 10 cycles in RESPOND → rsp_valid, rsp_pixel and rsp_id stable; req_ready stays 0; busy=1; released on the cycle rsp_ready rises.
- Reset pulse in WAIT → next cycle all outputs 0, state IDLE, no rsp_valid ever produced for the dropped operation; the next grant goes to req 0.
- CELL_LATENCY=1 with the cell model changing cell_result every cycle → the captured value equals the value present exactly one cycle after the cell_start cycle.
